// File: rtl/imm_pkg.sv
// Shared types and constants for the pipelined immediate generator.
package imm_pkg;

  localparam int IMM_W     = 16;
  localparam int JIDX_W    = 26;
  localparam int XLEN_MAX  = 64;
  localparam int TAG_W_MAX = 16;

  typedef enum logic [2:0] {
    IMM_ZERO   = 3'd0,
    IMM_SIGN   = 3'd1,
    IMM_LUI    = 3'd2,
    IMM_BRANCH = 3'd3,
    IMM_SHAMT  = 3'd4,
    IMM_JUMP   = 3'd5
  } imm_mode_e;

  // Sized for the widest configuration; narrower instances leave the top bits at zero.
  typedef struct packed {
    logic [XLEN_MAX-1:0]  ext;
    logic [TAG_W_MAX-1:0] tag;
    logic                 illegal;
  } imm_res_t;

endpackage

// File: rtl/imm_extend_core.sv
// Combinational mode decode and immediate extension for one decode slot.
module imm_extend_core
  import imm_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [JIDX_W-1:0] imm_i,
  input  logic [2:0]        mode_i,
  input  logic [XLEN-1:0]   pc_i,
  output logic [XLEN-1:0]   ext_o,
  output logic              illegal_o
);

  logic        [IMM_W-1:0] imm16;
  logic signed [IMM_W-1:0] imm16_s;
  logic signed [31:0]      lui32;
  logic        [XLEN-1:0]  sext;
  logic                    unused_pc;

  assign imm16   = imm_i[IMM_W-1:0];
  assign imm16_s = imm16;
  assign lui32   = {imm16, 16'h0};
  assign sext    = XLEN'(imm16_s);
  // Jump keeps only the PC region bits above the 256 MB segment.
  assign unused_pc = ^pc_i[27:0];

  always_comb begin
    ext_o     = '0;
    illegal_o = 1'b0;
    case (mode_i)
      IMM_ZERO:   ext_o = XLEN'(imm16);
      IMM_SIGN:   ext_o = sext;
      IMM_LUI:    ext_o = XLEN'(lui32);
      IMM_BRANCH: ext_o = sext << 2;
      IMM_SHAMT:  ext_o = XLEN'(imm_i[10:6]);
      IMM_JUMP:   ext_o = {pc_i[XLEN-1:28], imm_i, 2'b00};
      default:    illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/imm_extend_pipe.sv
// Pipelined immediate generator: one output register plus a single skid entry
// so a registered in_ready still sustains one item per cycle under backpressure.
module imm_extend_pipe
  import imm_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [25:0]       in_imm,
  input  logic [2:0]        in_mode,
  input  logic [XLEN-1:0]   in_pc,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_ext,
  output logic [TAG_W-1:0]  out_tag,
  output logic              out_illegal
);

  if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
    $error("imm_extend_pipe: XLEN must be 32 or 64");
  end
  if (TAG_W < 1 || TAG_W > TAG_W_MAX) begin : g_bad_tag
    $error("imm_extend_pipe: TAG_W out of range");
  end

  logic [XLEN-1:0] core_ext;
  logic            core_ill;

  imm_extend_core #(.XLEN(XLEN)) u_core (
    .imm_i     (in_imm),
    .mode_i    (in_mode),
    .pc_i      (in_pc),
    .ext_o     (core_ext),
    .illegal_o (core_ill)
  );

  imm_res_t in_item, out_q, out_d, skid_q, skid_d;
  logic     out_vld_q, out_vld_d, skid_vld_q, skid_vld_d, rdy_q;
  logic     in_xfer, out_free;
  logic     unused_hi;

  always_comb begin
    in_item                 = '0;
    in_item.ext[XLEN-1:0]   = core_ext;
    in_item.tag[TAG_W-1:0]  = in_tag;
    in_item.illegal         = core_ill;
  end

  assign in_xfer  = in_valid & rdy_q;
  assign out_free = !out_vld_q || out_ready;

  always_comb begin
    out_d      = out_q;
    out_vld_d  = out_vld_q;
    skid_d     = skid_q;
    skid_vld_d = skid_vld_q;
    if (out_free) begin
      if (skid_vld_q) begin
        // Older skid item goes first; a concurrent arrival refills the skid.
        out_d      = skid_q;
        out_vld_d  = 1'b1;
        skid_vld_d = in_xfer;
        if (in_xfer) skid_d = in_item;
      end else begin
        out_vld_d = in_xfer;
        if (in_xfer) out_d = in_item;
      end
    end else if (in_xfer) begin
      skid_d     = in_item;
      skid_vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_q      <= '0;
      skid_q     <= '0;
      out_vld_q  <= 1'b0;
      skid_vld_q <= 1'b0;
      rdy_q      <= 1'b0;
    end else begin
      out_q      <= out_d;
      skid_q     <= skid_d;
      out_vld_q  <= out_vld_d;
      skid_vld_q <= skid_vld_d;
      rdy_q      <= !skid_vld_d;
    end
  end

  assign in_ready    = rdy_q;
  assign out_valid   = out_vld_q;
  assign out_ext     = out_q.ext[XLEN-1:0];
  assign out_tag     = out_q.tag[TAG_W-1:0];
  assign out_illegal = out_q.illegal;
  assign unused_hi   = ^{out_q, skid_q};

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Random and directed stimulus into 32- and 64-bit instances, scoreboarded
// against an arithmetic reference model and an occupancy model of the buffer.
module tb_imm_extend_pipe;

  localparam int TAG_W = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              out_ready = 1'b0;
  logic [25:0]       in_imm = '0;
  logic [2:0]        in_mode = '0;
  logic [63:0]       in_pc = '0;
  logic [TAG_W-1:0]  in_tag = '0;

  logic              rdy32, vld32, ill32, rdy64, vld64, ill64;
  logic [31:0]       ext32;
  logic [63:0]       ext64;
  logic [TAG_W-1:0]  tag32, tag64;

  always #5 clk = ~clk;

  imm_extend_pipe #(.XLEN(32), .TAG_W(TAG_W)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy32),
    .in_imm(in_imm), .in_mode(in_mode), .in_pc(in_pc[31:0]), .in_tag(in_tag),
    .out_valid(vld32), .out_ready(out_ready), .out_ext(ext32),
    .out_tag(tag32), .out_illegal(ill32)
  );

  imm_extend_pipe #(.XLEN(64), .TAG_W(TAG_W)) u_dut64 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy64),
    .in_imm(in_imm), .in_mode(in_mode), .in_pc(in_pc), .in_tag(in_tag),
    .out_valid(vld64), .out_ready(out_ready), .out_ext(ext64),
    .out_tag(tag64), .out_illegal(ill64)
  );

  typedef struct {
    logic [63:0]      ext;
    logic [TAG_W-1:0] tag;
    logic             ill;
  } exp_t;

  exp_t        q32[$];
  exp_t        q64[$];
  int          n_chk = 0;
  int          n_pass = 0;
  int          occ = 0;
  int          n_out = 0;
  bit          stall_prev = 0;
  bit          saw_full = 0;
  logic [63:0] p_ext32, p_ext64;
  logic [TAG_W-1:0] p_tag;
  logic        p_ill;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  // Spec rules written as integer arithmetic on a 64-bit value, then truncated.
  function automatic logic [63:0] ref_ext(input int xlen, input logic [2:0] mode,
                                          input logic [25:0] imm, input logic [63:0] pc);
    longint      s;
    logic [63:0] r;
    logic [63:0] u;
    u = 64'(imm[15:0]);
    s = imm[15] ? longint'(u) - 65536 : longint'(u);
    case (mode)
      3'd0:    r = u;
      3'd1:    r = s;
      3'd2:    r = s * 65536;
      3'd3:    r = s * 4;
      3'd4:    r = (64'(imm) / 64) % 32;
      3'd5:    r = pc - (pc % 64'h1000_0000) + 64'(imm) * 4;
      default: r = 64'd0;
    endcase
    if (xlen == 32) r = r & 64'hFFFF_FFFF;
    return r;
  endfunction

  task automatic cyc(input logic v, input logic [2:0] m, input logic [25:0] imm,
                     input logic [63:0] pc, input logic [TAG_W-1:0] t, input logic ordy);
    exp_t e;
    @(negedge clk);
    in_valid = v; in_mode = m; in_imm = imm; in_pc = pc; in_tag = t; out_ready = ordy;
    #1;
    if (!rst_n) begin
      chk("rst_vld32", vld32, 0);   chk("rst_vld64", vld64, 0);
      chk("rst_ext32", ext32, 0);   chk("rst_ext64", ext64, 0);
      chk("rst_tag32", tag32, 0);   chk("rst_ill32", ill32, 0);
      chk("rst_rdy32", rdy32, 0);   chk("rst_rdy64", rdy64, 0);
      q32.delete(); q64.delete(); occ = 0; stall_prev = 0;
    end else begin
      chk("in_ready32", rdy32, occ < 2);
      chk("in_ready64", rdy64, occ < 2);
      chk("out_valid32", vld32, occ > 0);
      chk("out_valid64", vld64, occ > 0);
      if (!rdy32) saw_full = 1;
      if (stall_prev) begin
        chk("hold_ext32", ext32, p_ext32);
        chk("hold_ext64", ext64, p_ext64);
        chk("hold_tag", tag32, p_tag);
        chk("hold_ill", ill32, p_ill);
      end
      if (vld32 && out_ready) begin
        if (q32.size() == 0) chk("sb_underflow32", 1, 0);
        else begin
          e = q32.pop_front();
          chk("ext32", ext32, e.ext); chk("tag32", tag32, e.tag); chk("ill32", ill32, e.ill);
        end
        n_out++;
        occ--;
      end
      if (vld64 && out_ready) begin
        if (q64.size() == 0) chk("sb_underflow64", 1, 0);
        else begin
          e = q64.pop_front();
          chk("ext64", ext64, e.ext); chk("tag64", tag64, e.tag); chk("ill64", ill64, e.ill);
        end
      end
      if (in_valid && rdy32) begin
        e.tag = in_tag; e.ill = (in_mode >= 3'd6);
        e.ext = ref_ext(32, in_mode, in_imm, in_pc); q32.push_back(e);
        e.ext = ref_ext(64, in_mode, in_imm, in_pc); q64.push_back(e);
        occ++;
      end
      stall_prev = vld32 && !out_ready;
      p_ext32 = 64'(ext32); p_ext64 = ext64; p_tag = tag32; p_ill = ill32;
    end
  endtask

  initial begin
    int nt, k, base;
    bit v;
    // Reset held three cycles with a valid item pending at the input.
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) cyc(1, 3'd1, 26'h1234, 64'd0, 4'h5, 1);
    @(negedge clk); in_valid = 0; rst_n = 1'b1;

    // Directed: one-cycle latency and each mode's worked example.
    cyc(1, 3'd0, 26'h8001, 64'd0, 4'h1, 1);
    cyc(1, 3'd1, 26'h8001, 64'd0, 4'h2, 1);
    chk("zero32", 64'(ext32), 64'h0000_8001);
    chk("zero64", ext64, 64'h0000_0000_0000_8001);
    cyc(1, 3'd2, 26'h8001, 64'd0, 4'h3, 1);
    chk("sign32", 64'(ext32), 64'hFFFF_8001);
    cyc(1, 3'd3, 26'hFFFF, 64'd0, 4'h4, 1);
    chk("lui32", 64'(ext32), 64'h8001_0000);
    chk("lui64", ext64, 64'hFFFF_FFFF_8001_0000);
    cyc(1, 3'd4, 26'h07C0, 64'd0, 4'h5, 1);
    chk("branch32", 64'(ext32), 64'hFFFF_FFFC);
    cyc(1, 3'd5, 26'h0100000, 64'h4000_1000, 4'h6, 1);
    chk("shamt32", 64'(ext32), 64'h1F);
    cyc(1, 3'd6, 26'h1234, 64'd0, 4'hA, 1);
    chk("jump32", 64'(ext32), 64'h4040_0000);
    cyc(1, 3'd1, 26'h1234, 64'd0, 4'hB, 1);
    chk("illegal_ext", 64'(ext32), 0);
    chk("illegal_flag", ill32, 1);
    chk("illegal_tag", tag32, 4'hA);
    cyc(0, 3'd0, 26'd0, 64'd0, 4'h0, 1);
    chk("legal_after_ill", ill32, 0);
    chk("legal_tag", tag32, 4'hB);
    cyc(0, 3'd0, 26'd0, 64'd0, 4'h0, 1);

    // Backpressure: tags 1..6, output stalled for three cycles after tag 2.
    nt = 1; k = 0; base = n_out; saw_full = 0;
    while ((n_out - base) < 6 && k < 60) begin
      v = (nt <= 6);
      cyc(v, 3'($urandom_range(0, 5)), 26'($urandom), {$urandom, $urandom},
          TAG_W'(nt), !(k >= 3 && k <= 5));
      if (v && rdy32) nt++;
      k++;
    end
    chk("bp_count", n_out - base, 6);
    chk("bp_skid_filled", saw_full, 1);

    // Random traffic, including illegal modes.
    for (int i = 0; i < 400; i++)
      cyc(($urandom_range(0, 9) < 7), 3'($urandom), 26'($urandom), {$urandom, $urandom},
          TAG_W'($urandom), ($urandom_range(0, 9) < 6));
    for (int i = 0; i < 4; i++) cyc(0, 3'd0, 26'd0, 64'd0, 4'h0, 1);
    chk("drain32", q32.size(), 0);
    chk("drain64", q64.size(), 0);

    // Reset with both entries occupied discards everything.
    for (int i = 0; i < 4; i++) cyc(1, 3'd1, 26'($urandom), 64'd0, TAG_W'(i), 0);
    chk("full_before_rst", occ, 2);
    @(negedge clk); rst_n = 1'b0;
    cyc(1, 3'd1, 26'h0FFF, 64'd0, 4'h7, 1);
    @(negedge clk); in_valid = 0; rst_n = 1'b1;
    cyc(0, 3'd0, 26'd0, 64'd0, 4'h0, 1);
    cyc(1, 3'd2, 26'h00F0, 64'd0, 4'h9, 1);
    cyc(0, 3'd0, 26'd0, 64'd0, 4'h0, 1);
    chk("post_rst_tag", tag32, 4'h9);
    cyc(0, 3'd0, 26'd0, 64'd0, 4'h0, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
